banco_registradores: RTL
========================

// Module: banco_registradores
// PURPOSE
//   8-entry register file downstream of the 3-bit write-address select mux.
//   The mux output drives EnderecoEscrita; two read ports feed the ALU operand path.
//   Writes pass through a one-entry write-back buffer before committing to the array.
//   Reads are registered (1-cycle latency) with full forwarding, so a value is never stale.
// PARAMETERS
//   LARGURA   16  data width of each register
//   R0_ZERO   1   1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary
// PORTS
//   Clock              in   1        single clock; all state updates on rising edge
//   Reset              in   1        synchronous, active-high
//   EscritaHabilitada  in   1        write request this cycle
//   EnderecoEscrita    in   3        write address (from the 3-bit mux output)
//   DadoEscrita        in   LARGURA  write data
//   EnderecoLeitura1   in   3        read port 1 address
//   EnderecoLeitura2   in   3        read port 2 address
//   DadoLeitura1       out  LARGURA  registered read data, port 1
//   DadoLeitura2       out  LARGURA  registered read data, port 2
//   EscritaPendente    out  1        write-back buffer holds an uncommitted write
// BEHAVIOUR
//   State: Regs[0..7] (LARGURA each); WB = {WbValido, WbEnd[2:0], WbDado}.
//   Reset (sampled on edge, highest priority): all Regs=0, WbValido=0, WbEnd=0,
//     WbDado=0, DadoLeitura1/2=0, EscritaPendente=0. Pending WB write discarded.
//     Write and read requests in the same cycle as Reset are ignored.
//   Write accept (edge k): WbValido<=EscritaHabilitada & ~(R0_ZERO & EnderecoEscrita==0);
//     WbEnd<=EnderecoEscrita; WbDado<=DadoEscrita. Buffer is overwritten every cycle.
//   Commit (edge k+1): if WbValido then Regs[WbEnd]<=WbDado. Commit and new accept
//     happen on the same edge; no stall, no backpressure, never full.
//   EscritaPendente = WbValido (registered, no combinational path from inputs).
//   Read (each edge, per port p, address A): DadoLeituraP <= first match of
//     1) R0_ZERO & A==0                                   -> 0
//     2) EscritaHabilitada & EnderecoEscrita==A (accepted) -> DadoEscrita
//     3) WbValido & WbEnd==A                              -> WbDado
//     4) otherwise                                        -> Regs[A]
//   Latency: address at edge k -> data valid after edge k (stable through cycle k+1).
//   Write at edge k is visible on a read sampled at edge k (via rule 2), k+1 (rule 3), later (array).
//   Back-to-back writes to same address: newest wins (rule 2 over rule 3; commit order).
//   Both ports same address: identical data. Widths: no arithmetic, no truncation.
//   Write to reg 0 with R0_ZERO=1: dropped, EscritaPendente stays 0.
// TESTING
//   1 Reset 2 cycles, read all 8 addrs on both ports -> every DadoLeitura = 0, EscritaPendente=0.
//   2 Write R5=16'hA5A5 at edge k, Leitura1=5 at edge k -> DadoLeitura1=A5A5 after edge k;
//     EscritaPendente=1 after k, 0 after k+1 if no further write; read at k+3 still A5A5.
//   3 Write R3=16'h1111 at edge k, R3=16'h2222 at edge k+1, read R3 at k+1 and k+2
//     -> 2222 both times; array holds 2222 after k+2.
//   4 R0_ZERO=1: write R0=16'hFFFF, read R0 same and next cycle -> 0, EscritaPendente=0;
//     rerun with R0_ZERO=0 -> reads FFFF.
//   5 Write R7=16'h00FF at edge k, Reset=1 at edge k+1 -> R7 reads 0 afterwards, all outputs 0.
//   6 Both ports addr 2, write R2=16'h0042 -> DadoLeitura1=DadoLeitura2=0042 same edge.

Source files
------------

// File: rtl/banco_registradores.sv
// banco_registradores: 8-entry register file with a one-entry write-back buffer
// and registered, fully forwarded read ports.
//   Clock             : single clock, rising edge
//   Reset             : synchronous, active-high; clears array, buffer and outputs
//   EscritaHabilitada : write request
//   EnderecoEscrita   : write address
//   DadoEscrita       : write data
//   EnderecoLeitura1/2: read addresses
//   DadoLeitura1/2    : registered read data (1-cycle latency)
//   EscritaPendente   : write-back buffer holds an uncommitted write
module banco_registradores #(
  parameter int unsigned LARGURA = 16,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               EscritaHabilitada,
  input  logic [2:0]         EnderecoEscrita,
  input  logic [LARGURA-1:0] DadoEscrita,
  input  logic [2:0]         EnderecoLeitura1,
  input  logic [2:0]         EnderecoLeitura2,
  output logic [LARGURA-1:0] DadoLeitura1,
  output logic [LARGURA-1:0] DadoLeitura2,
  output logic               EscritaPendente
);

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned NUM_PORTAS = 2;

  logic [LARGURA-1:0] regs [NUM_REGS];
  logic               wb_valido;
  logic [2:0]         wb_end;
  logic [LARGURA-1:0] wb_dado;

  logic               aceita_c;
  logic [2:0]         end_leitura [NUM_PORTAS];
  logic [LARGURA-1:0] leitura_c   [NUM_PORTAS];

  // Writes to register 0 are dropped when it is hard-wired to zero.
  assign aceita_c = EscritaHabilitada & ~(R0_ZERO & (EnderecoEscrita == 3'd0));

  assign end_leitura[0] = EnderecoLeitura1;
  assign end_leitura[1] = EnderecoLeitura2;

  // Read priority, lowest first so later assignments win:
  // array < write-back buffer < same-cycle write < hard-wired zero.
  always_comb begin
    for (int p = 0; p < NUM_PORTAS; p++) begin
      leitura_c[p] = regs[end_leitura[p]];
      if (wb_valido && (wb_end == end_leitura[p])) begin
        leitura_c[p] = wb_dado;
      end
      if (aceita_c && (EnderecoEscrita == end_leitura[p])) begin
        leitura_c[p] = DadoEscrita;
      end
      if (R0_ZERO && (end_leitura[p] == 3'd0)) begin
        leitura_c[p] = '0;
      end
    end
  end

  // Buffer accept, array commit and read registers share the same edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      wb_valido    <= 1'b0;
      wb_end       <= 3'd0;
      wb_dado      <= '0;
      DadoLeitura1 <= '0;
      DadoLeitura2 <= '0;
    end else begin
      if (wb_valido) begin
        regs[wb_end] <= wb_dado;
      end
      wb_valido    <= aceita_c;
      wb_end       <= EnderecoEscrita;
      wb_dado      <= DadoEscrita;
      DadoLeitura1 <= leitura_c[0];
      DadoLeitura2 <= leitura_c[1];
    end
  end

  assign EscritaPendente = wb_valido;

endmodule
